// File: rtl/prio_enc_seq.sv
// rtl/prio_enc_seq.sv - registered N-input priority encoder with valid/ready index output
//
// Request bits are ORed into a pending register and served one per handshake.
// The selected index is loaded into a single-entry output register and its
// pending bit is cleared in the same edge. A request bit arriving on the edge
// its pending bit is cleared stays pending (set wins).
//
// Optional feature macro: PRIO_ENC_ROUND_ROBIN_EN
//   defined   : round-robin selection, scan upward from (ptr+1) mod N
//   undefined : fixed priority, highest set index wins, no pointer state
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   en         in   enable; low freezes pending (req dropped) and blocks loads
//   req        in   [N-1:0] request lines, ORed into pending
//   out_idx    out  [W-1:0] index of the served request
//   out_valid  out  out_idx holds an unconsumed result
//   out_ready  in   consumer accepts when out_valid && out_ready
//   pending    out  [N-1:0] current pending register
//   zero       out  nothing pending and nothing on the output

module prio_enc_seq #(
   parameter int N = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [N-1:0]         req,
   output logic [$clog2(N)-1:0] out_idx,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N-1:0]         pending,
   output logic                 zero
);

   localparam int W = $clog2(N);

   logic [N-1:0] pending_q, pending_d;
   logic [W-1:0] out_idx_q, out_idx_d;
   logic         out_valid_q, out_valid_d;

   logic [W-1:0] sel;
   logic [N-1:0] clr;
   logic         fire;
   logic         load;

`ifdef PRIO_ENC_ROUND_ROBIN_EN
   logic [W-1:0] ptr_q, ptr_d;
   logic         found;
   logic [W-1:0] scan_idx;
   int           scan_pos;

   // First set bit at or after ptr+1, wrapping at N-1. Starting at offset 1
   // means the last-served index is considered only after every other bit.
   always_comb begin
      sel      = '0;
      found    = 1'b0;
      scan_pos = 0;
      scan_idx = '0;
      for (int k = 1; k <= N; k++) begin
         scan_pos = (int'(ptr_q) + k) % N;
         scan_idx = scan_pos[W-1:0];
         if (!found && pending_q[scan_idx]) begin
            found = 1'b1;
            sel   = scan_idx;
         end
      end
   end
`else
   // Later iterations overwrite earlier ones, so the highest set index wins.
   always_comb begin
      sel = '0;
      for (int i = 0; i < N; i++) begin
         if (pending_q[i]) begin
            sel = i[W-1:0];
         end
      end
   end
`endif

   always_comb begin
      fire = out_valid_q && out_ready;
      load = en && (pending_q != '0) && (!out_valid_q || fire);

      clr = '0;
      if (load) begin
         clr[sel] = 1'b1;
      end

      // req is dropped, not buffered, while en is low.
      pending_d = pending_q;
      if (en) begin
         pending_d = (pending_q & ~clr) | req;
      end

      out_valid_d = out_valid_q;
      out_idx_d   = out_idx_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_idx_d   = sel;
      end else if (fire) begin
         out_valid_d = 1'b0;
      end
   end

`ifdef PRIO_ENC_ROUND_ROBIN_EN
   always_comb begin
      ptr_d = ptr_q;
      if (load) begin
         ptr_d = sel;
      end
   end

   // Reset to N-1 so the first scan after reset starts at bit 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= W'(N - 1);
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q   <= '0;
         out_idx_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         pending_q   <= pending_d;
         out_idx_q   <= out_idx_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_idx   = out_idx_q;
   assign out_valid = out_valid_q;
   assign pending   = pending_q;
   assign zero      = (pending_q == '0) && !out_valid_q;

endmodule

// File: tb/tb_prio_enc_seq.sv
// tb/tb_prio_enc_seq.sv - self-checking bench for prio_enc_seq (N=8)

module tb_prio_enc_seq;

   localparam int N = 8;
   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic [N-1:0] req;
   logic [W-1:0] out_idx;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] pending;
   logic         zero;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [W-1:0] sb[$];

   logic         stall_seen = 1'b0;
   logic [W-1:0] stall_idx  = '0;

   always #5 clk = ~clk;

   prio_enc_seq #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req       (req),
      .out_idx   (out_idx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pending   (pending),
      .zero      (zero)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(output int cycles);
      cycles = 0;
      while (!(zero === 1'b1 && sb.size() == 0) && cycles < 40) begin
         tick();
         cycles++;
      end
      if (cycles >= 40) begin
         total_cnt++;
         $display("FAIL drain_timeout: got busy after %0d cycles expected idle", cycles);
      end
   endtask

   // Scoreboard: every accepted output is popped and compared; a stalled
   // output must keep its index until accepted.
   always @(negedge clk) begin
      if (rst !== 1'b0) begin
         stall_seen = 1'b0;
      end else begin
         if (stall_seen && out_valid) begin
            check("hold_idx", 64'(out_idx), 64'(stall_idx));
         end
         stall_seen = out_valid && !out_ready;
         stall_idx  = out_idx;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               total_cnt++;
               $display("FAIL unexpected_issue: got idx %0d expected no issue", out_idx);
            end else begin
               check("issue_idx", 64'(out_idx), 64'(sb.pop_front()));
            end
         end
      end
   end

   typedef struct {
      logic [N-1:0]        req;
      int                  bp;
      int                  n;
      logic [7:0][W-1:0]   seq;
      logic [N-1:0]        pend_held;
   } vec_t;

   initial begin
      vec_t vecs[6];
      int   cyc;

      vecs[0] = '{req: 8'b0010_0000, bp: 0, n: 1, seq: {8{3'd0}} | 24'd5, pend_held: 8'h00};
      vecs[1] = '{req: 8'b1000_0101, bp: 0, n: 3, seq: {15'd0, 3'd0, 3'd2, 3'd7}, pend_held: 8'h00};
      vecs[2] = '{req: 8'b1000_0101, bp: 4, n: 3, seq: {15'd0, 3'd0, 3'd2, 3'd7}, pend_held: 8'b0000_0101};
      vecs[3] = '{req: 8'hFF, bp: 0, n: 8,
                  seq: {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}, pend_held: 8'h00};
      vecs[4] = '{req: 8'h01, bp: 0, n: 1, seq: 24'd0, pend_held: 8'h00};
      vecs[5] = '{req: 8'b0001_1000, bp: 2, n: 2, seq: {18'd0, 3'd3, 3'd4}, pend_held: 8'b0000_1000};

      // Reset with all requests asserted.
      rst = 1'b1; en = 1'b1; req = 8'hFF; out_ready = 1'b1;
      tick();
      tick();
      check("rst_pending", 64'(pending), 64'h0);
      check("rst_valid", 64'(out_valid), 64'h0);
      check("rst_idx", 64'(out_idx), 64'h0);
      check("rst_zero", 64'(zero), 64'h1);
      rst = 1'b0; req = '0;

      // Latency: req at edge t, out_valid after t+1, for one cycle only.
      req = 8'b0010_0000; sb.push_back(3'd5);
      tick();
      req = '0;
      check("lat_valid_t", 64'(out_valid), 64'h0);
      check("lat_pend_t", 64'(pending), 64'h20);
      tick();
      check("lat_valid_t1", 64'(out_valid), 64'h1);
      check("lat_idx_t1", 64'(out_idx), 64'h5);
      tick();
      check("lat_valid_t2", 64'(out_valid), 64'h0);
      check("lat_zero_t2", 64'(zero), 64'h1);

      // Set wins: bit 7 re-requested on the edge it is loaded issues twice.
      req = 8'h80; sb.push_back(3'd7); sb.push_back(3'd7);
      tick();
      tick();
      check("setwin_pend", 64'(pending), 64'h80);
      req = '0;
      drain(cyc);
      check("setwin_drain", 64'(cyc), 64'd2);

      // en low drops requests.
      en = 1'b0; req = 8'h01;
      tick();
      en = 1'b1; req = '0;
      check("en_drop_pend", 64'(pending), 64'h0);
      check("en_drop_zero", 64'(zero), 64'h1);
      tick();
      check("en_drop_valid", 64'(out_valid), 64'h0);

      // rst mid-handshake discards the held result.
      out_ready = 1'b0; req = 8'h12;
      tick();
      req = '0;
      tick();
      check("midrst_valid_before", 64'(out_valid), 64'h1);
      rst = 1'b1; sb.delete();
      tick();
      check("midrst_valid", 64'(out_valid), 64'h0);
      check("midrst_pend", 64'(pending), 64'h0);
      check("midrst_idx", 64'(out_idx), 64'h0);
      check("midrst_zero", 64'(zero), 64'h1);
      rst = 1'b0; out_ready = 1'b1;
      tick();

`ifndef PRIO_ENC_ROUND_ROBIN_EN
      // In-flight result completes while en is low; no new load.
      out_ready = 1'b0; req = 8'h03;
      tick();
      req = '0;
      tick();
      check("enoff_idx", 64'(out_idx), 64'h1);
      check("enoff_pend_a", 64'(pending), 64'h01);
      en = 1'b0; out_ready = 1'b1; sb.push_back(3'd1);
      tick();
      check("enoff_valid", 64'(out_valid), 64'h0);
      check("enoff_pend_b", 64'(pending), 64'h01);
      check("enoff_zero", 64'(zero), 64'h0);
      en = 1'b1; sb.push_back(3'd0);
      tick();
      check("enoff_reload", 64'(out_idx), 64'h0);
      drain(cyc);

      // Table-driven fixed-priority vectors.
      for (int v = 0; v < 6; v++) begin
         req = vecs[v].req;
         out_ready = (vecs[v].bp == 0);
         for (int k = 0; k < vecs[v].n; k++) begin
            sb.push_back(vecs[v].seq[k]);
         end
         tick();
         req = '0;
         if (vecs[v].bp > 0) begin
            tick();
            repeat (vecs[v].bp - 1) tick();
            check($sformatf("v%0d_held_pend", v), 64'(pending), 64'(vecs[v].pend_held));
            check($sformatf("v%0d_held_idx", v), 64'(out_idx), 64'(vecs[v].seq[0]));
            check($sformatf("v%0d_held_valid", v), 64'(out_valid), 64'h1);
            out_ready = 1'b1;
         end
         drain(cyc);
         check($sformatf("v%0d_drain_cycles", v), 64'(cyc),
               64'(vecs[v].bp == 0 ? vecs[v].n + 1 : vecs[v].n));
         check($sformatf("v%0d_zero", v), 64'(zero), 64'h1);
      end
`else
      // Round robin from reset with req=8'b1000_0101 held for 6 edges.
      rst = 1'b1;
      tick();
      rst = 1'b0; out_ready = 1'b1; req = 8'b1000_0101;
      sb.push_back(3'd0); sb.push_back(3'd2); sb.push_back(3'd7);
      sb.push_back(3'd0); sb.push_back(3'd2); sb.push_back(3'd7);
      sb.push_back(3'd0); sb.push_back(3'd2);
      repeat (6) tick();
      req = '0;
      drain(cyc);
      check("rr_drain_cycles", 64'(cyc), 64'd4);
      check("rr_zero", 64'(zero), 64'h1);
`endif

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
